// File: rtl/kernel_launch_queue.sv
//==============================================================================
// Module      : kernel_launch_queue
// Description : Launch descriptor FIFO and sequencer for the gpu top; returns
//               one completion record (tag, cycles, timeout) per launch.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module kernel_launch_queue #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TAG_WIDTH      = 8,
    parameter int CYCLE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CONFIG_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            launch_valid,
    output logic                            launch_ready,
    input  logic [CONFIG_WIDTH-1:0]         launch_config,
    input  logic [TAG_WIDTH-1:0]            launch_tag,
    output logic [CONFIG_WIDTH-1:0]         kernel_config,
    output logic                            gpu_reset,
    output logic                            execution_start,
    input  logic                            execution_done,
    output logic                            complete_valid,
    input  logic                            complete_ready,
    output logic [TAG_WIDTH-1:0]            complete_tag,
    output logic [CYCLE_WIDTH-1:0]          complete_cycles,
    output logic                            complete_timeout,
    output logic                            busy,
    output logic [$clog2(QUEUE_DEPTH):0]    queue_count
);

    localparam int                     c_ptr_w        = $clog2(QUEUE_DEPTH);
    localparam logic [c_ptr_w:0]       c_depth        = (c_ptr_w + 1)'(QUEUE_DEPTH);
    localparam logic                   c_watchdog_en  = (TIMEOUT_CYCLES != 0);
    localparam logic [CYCLE_WIDTH-1:0] c_timeout_last =
        CYCLE_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_reset  = 3'd1;
    localparam logic [2:0] c_s_start  = 3'd2;
    localparam logic [2:0] c_s_run    = 3'd3;
    localparam logic [2:0] c_s_retire = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;

    logic [CONFIG_WIDTH-1:0] r_cfg_mem [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]    r_tag_mem [QUEUE_DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_ptr_w:0]        r_count;

    logic [CONFIG_WIDTH-1:0] r_config;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic [CYCLE_WIDTH-1:0]  r_cycles;
    logic                    r_timeout_hit;

    logic                    r_cpl_valid;
    logic [TAG_WIDTH-1:0]    r_cpl_tag;
    logic [CYCLE_WIDTH-1:0]  r_cpl_cycles;
    logic                    r_cpl_timeout;

    logic                    w_launch_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_watchdog_hit;
    logic                    w_busy;
    logic                    w_exec_start;
    logic                    w_gpu_reset;

    // Occupancy is the registered count only: no full- or empty-bypass.
    assign w_launch_ready = (r_count < c_depth);
    assign w_push         = launch_valid && w_launch_ready;
    assign w_pop          = (r_state == c_s_idle) && (r_count != '0) && !r_cpl_valid;
    assign w_watchdog_hit = c_watchdog_en && (r_cycles == c_timeout_last);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle:   if (w_pop) w_next_state = c_s_reset;
            c_s_reset:  w_next_state = c_s_start;
            c_s_start:  w_next_state = c_s_run;
            c_s_run:    if (execution_done || w_watchdog_hit) w_next_state = c_s_retire;
            c_s_retire: w_next_state = c_s_idle;
            default:    w_next_state = c_s_idle;
        endcase
    end

    // Output decode; gpu_reset also follows the block reset asynchronously.
    always_comb begin
        w_busy       = (r_state != c_s_idle);
        w_exec_start = (r_state == c_s_start);
        w_gpu_reset  = reset || (r_state == c_s_reset)
                       || ((r_state == c_s_retire) && r_timeout_hit);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_cfg_mem[r_wr_ptr] <= launch_config;
            r_tag_mem[r_wr_ptr] <= launch_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Launch datapath: config/tag latched at pop and held until the next pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_config      <= '0;
            r_tag         <= '0;
            r_cycles      <= '0;
            r_timeout_hit <= 1'b0;
        end else begin
            if (w_pop) begin
                r_config <= r_cfg_mem[r_rd_ptr];
                r_tag    <= r_tag_mem[r_rd_ptr];
            end
            if (r_state == c_s_start) begin
                r_cycles      <= '0;
                r_timeout_hit <= 1'b0;
            end else if (r_state == c_s_run) begin
                if (r_cycles != '1) r_cycles <= r_cycles + CYCLE_WIDTH'(1);
                r_timeout_hit <= !execution_done && w_watchdog_hit;
            end
        end
    end

    // r_cycles already holds the RUN-cycle count (count+1) once in RETIRE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpl_valid   <= 1'b0;
            r_cpl_tag     <= '0;
            r_cpl_cycles  <= '0;
            r_cpl_timeout <= 1'b0;
        end else if (r_state == c_s_retire) begin
            r_cpl_valid   <= 1'b1;
            r_cpl_tag     <= r_tag;
            r_cpl_cycles  <= r_cycles;
            r_cpl_timeout <= r_timeout_hit;
        end else if (r_cpl_valid && complete_ready) begin
            r_cpl_valid   <= 1'b0;
        end
    end

    assign launch_ready     = w_launch_ready;
    assign kernel_config    = r_config;
    assign gpu_reset        = w_gpu_reset;
    assign execution_start  = w_exec_start;
    assign complete_valid   = r_cpl_valid;
    assign complete_tag     = r_cpl_tag;
    assign complete_cycles  = r_cpl_cycles;
    assign complete_timeout = r_cpl_timeout;
    assign busy             = w_busy;
    assign queue_count      = r_count;

endmodule

`default_nettype wire
